// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq: operands and opcode in, registered
// result, flags and the start/busy/done handshake out.
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [2:0]       operation;
  logic [WIDTH-1:0] in_bus;
  logic [WIDTH-1:0] in_AC;
  logic [WIDTH-1:0] data_out;
  logic             zero;
  logic             carry;
  logic             busy;
  logic             done;

  modport master (
    output start, operation, in_bus, in_AC,
    input  data_out, zero, carry, busy, done
  );

  modport slave (
    input  start, operation, in_bus, in_AC,
    output data_out, zero, carry, busy, done
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with zero/carry flags. Single-cycle ops complete at the
// accepting edge; MUL runs a WIDTH-step shift-add loop while busy is high.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input logic     clk,
  input logic     rst,
  alu_seq_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_PASS_B = 3'd0;
  localparam logic [2:0] OP_ADD    = 3'd1;
  localparam logic [2:0] OP_SUB    = 3'd2;
  localparam logic [2:0] OP_MUL    = 3'd3;
  localparam logic [2:0] OP_INC    = 3'd4;
  localparam logic [2:0] OP_SHR    = 3'd5;
  localparam logic [2:0] OP_CLR    = 3'd6;
  localparam logic [2:0] OP_PASS_A = 3'd7;

  typedef enum logic {IDLE, MUL} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   prod;
  logic [2*WIDTH-1:0]   prod_step;
  logic [WIDTH:0]       alu_res;
  logic                 accept;
  logic                 mul_last;
  logic [WIDTH-1:0]     data_out_r;
  logic                 zero_r;
  logic                 carry_r;
  logic                 done_r;

  // Single-cycle result as {carry, value}; MUL never goes through here.
  function automatic logic [WIDTH:0] alu_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH:0] r;
    r = '0;
    case (op)
      OP_PASS_B: r = {1'b0, b};
      OP_ADD:    r = {1'b0, a} + {1'b0, b};
      OP_SUB:    r = {(a < b), a - b};
      OP_INC:    r = {(a == {WIDTH{1'b1}}), a + WIDTH'(1)};
      OP_SHR:    r = {a[0], 1'b0, a[WIDTH-1:1]};
      OP_CLR:    r = '0;
      OP_PASS_A: r = {1'b0, a};
      default:   r = '0;
    endcase
    return r;
  endfunction

  assign accept   = (state == IDLE) && bus.start;
  assign mul_last = (state == MUL) && (cnt == CNT_W'(1));
  assign alu_res  = alu_op(bus.operation, bus.in_AC, bus.in_bus);

  assign bus.data_out = data_out_r;
  assign bus.zero     = zero_r;
  assign bus.carry    = carry_r;
  assign bus.done     = done_r;
  assign bus.busy     = (state == MUL);

  // One shift-add step: accumulate the shifted multiplicand when the multiplier LSB is set.
  always_comb begin
    prod_step = prod;
    if (mplier[0]) prod_step = prod + mcand;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: MUL is entered on an accepted multiply and left on its final step.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start && bus.operation == OP_MUL) state_nxt = MUL;
      MUL:     if (cnt == CNT_W'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control and visible outputs: results/flags move only on completion or reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_r <= '0;
      zero_r     <= 1'b0;
      carry_r    <= 1'b0;
      done_r     <= 1'b0;
      cnt        <= '0;
    end else begin
      done_r <= 1'b0;
      if (accept) begin
        if (bus.operation == OP_MUL) begin
          cnt <= CNT_W'(WIDTH);
        end else begin
          data_out_r <= alu_res[WIDTH-1:0];
          carry_r    <= alu_res[WIDTH];
          zero_r     <= (alu_res[WIDTH-1:0] == '0);
          done_r     <= 1'b1;
        end
      end else if (state == MUL) begin
        cnt <= cnt - CNT_W'(1);
        if (mul_last) begin
          data_out_r <= prod_step[WIDTH-1:0];
          carry_r    <= |prod_step[2*WIDTH-1:WIDTH];
          zero_r     <= (prod_step[WIDTH-1:0] == '0);
          done_r     <= 1'b1;
        end
      end
    end
  end

  // Multiplier datapath: operands latched at acceptance, then shifted each MUL step.
  always_ff @(posedge clk) begin
    if (accept && bus.operation == OP_MUL) begin
      mcand  <= {{WIDTH{1'b0}}, bus.in_AC};
      mplier <= bus.in_bus;
      prod   <= '0;
    end else if (state == MUL) begin
      prod   <= prod_step;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=16 and WIDTH=8.
module tb_alu_seq;
  logic clk;
  logic rst;

  alu_seq_if #(.WIDTH(16)) bus16 ();
  alu_seq_if #(.WIDTH(8))  bus8 ();

  alu_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));
  alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));

  typedef struct {
    logic [31:0] res;
    logic        c;
  } exp_t;

  exp_t q16[$];
  exp_t q8[$];
  int   checks   = 0;
  int   failures = 0;
  int   dc16     = 0;
  int   dc8      = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic on wide unsigned integers, masked to w bits.
  function automatic logic [32:0] model(input int w, input logic [2:0] op,
                                        input logic [31:0] a, input logic [31:0] b);
    longint unsigned m, r, ua, ub;
    bit c;
    m  = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & m;
    ub = {32'd0, b} & m;
    c  = 1'b0;
    case (op)
      3'd0: r = ub;
      3'd1: begin r = ua + ub; c = ((r >> w) != 64'd0); end
      3'd2: begin r = ua - ub; c = (ua < ub); end
      3'd3: begin r = ua * ub; c = ((r >> w) != 64'd0); end
      3'd4: begin r = ua + 64'd1; c = (ua == m); end
      3'd5: begin r = ua >> 1; c = ua[0]; end
      3'd6: r = 64'd0;
      default: r = ua;
    endcase
    r = r & m;
    return {c, r[31:0]};
  endfunction

  task automatic sb_pop(input bit w8, input logic [31:0] d, input logic z, input logic c);
    exp_t e;
    int   sz;
    sz = w8 ? q8.size() : q16.size();
    if (sz == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_done w8=%0d actual=done required=no_done", w8);
    end else begin
      if (w8) e = q8.pop_front();
      else    e = q16.pop_front();
      check(w8 ? "data_out8" : "data_out16", {32'd0, d}, {32'd0, e.res});
      check(w8 ? "carry8" : "carry16", {63'd0, c}, {63'd0, e.c});
      check(w8 ? "zero8" : "zero16", {63'd0, z}, {63'd0, (e.res == 32'd0)});
    end
  endtask

  // Monitor: compare every completion against the head of the matching queue.
  always @(negedge clk) begin
    check("done_and_busy16", {63'd0, bus16.done & bus16.busy}, 64'd0);
    check("done_and_busy8", {63'd0, bus8.done & bus8.busy}, 64'd0);
    if (bus16.done) begin
      dc16++;
      sb_pop(1'b0, {16'd0, bus16.data_out}, bus16.zero, bus16.carry);
    end
    if (bus8.done) begin
      dc8++;
      sb_pop(1'b1, {24'd0, bus8.data_out}, bus8.zero, bus8.carry);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic idle();
    bus16.start = 1'b0;
    bus8.start  = 1'b0;
  endtask

  // Waits for the target to be free, presents a request for one edge, and
  // records the expected response (explicit or from the reference model).
  task automatic issue(input bit w8, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit directed,
                       input logic [31:0] eres, input logic ec);
    int          g;
    exp_t        e;
    logic [32:0] m;
    g = 0;
    while ((w8 ? bus8.busy : bus16.busy) && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 200) check("issue_wait_timeout", 64'd1, 64'd0);
    if (w8) begin
      bus8.start = 1'b1; bus8.operation = op; bus8.in_AC = a[7:0]; bus8.in_bus = b[7:0];
    end else begin
      bus16.start = 1'b1; bus16.operation = op; bus16.in_AC = a[15:0]; bus16.in_bus = b[15:0];
    end
    @(posedge clk); #1;
    m     = model(w8 ? 8 : 16, op, a, b);
    e.res = directed ? eres : m[31:0];
    e.c   = directed ? ec : m[32];
    if (w8) q8.push_back(e);
    else    q16.push_back(e);
  endtask

  task automatic count_busy(input bit w8, input int required, input string name);
    int n;
    n = 0;
    while ((w8 ? bus8.busy : bus16.busy) && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
    check(name, 64'(n), 64'(required));
  endtask

  task automatic random_run(input bit w8, input int n);
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < n; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: a = 32'hFFFF_FFFF;
        1: b = 32'd0;
        2: a = 32'd0;
        default: ;
      endcase
      issue(w8, op, a, b, 1'b0, 32'd0, 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        idle();
        tick(1);
      end
    end
    idle();
  endtask

  logic [2:0]  seq_op  [7] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7};
  logic [31:0] seq_res [7] = '{32'd2, 32'd7, 32'd3, 32'd6, 32'd2, 32'd0, 32'd5};
  logic        seq_c   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    int dc0;
    int g;
    idle();
    bus16.operation = 3'd0; bus16.in_AC = '0; bus16.in_bus = '0;
    bus8.operation  = 3'd0; bus8.in_AC  = '0; bus8.in_bus  = '0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    check("rst_data_out", {48'd0, bus16.data_out}, 64'd0);
    check("rst_zero", {63'd0, bus16.zero}, 64'd0);
    check("rst_carry", {63'd0, bus16.carry}, 64'd0);
    check("rst_busy", {63'd0, bus16.busy}, 64'd0);
    check("rst_done", {63'd0, bus16.done}, 64'd0);

    // Back-to-back single-cycle ops on A=5, B=2.
    dc0 = dc16;
    for (int i = 0; i < 7; i++) issue(1'b0, seq_op[i], 32'd5, 32'd2, 1'b1, seq_res[i], seq_c[i]);
    idle();
    tick(1);
    check("b2b_done_count", 64'(dc16 - dc0), 64'd7);

    issue(1'b0, 3'd2, 32'd2, 32'd5, 1'b1, 32'hFFFD, 1'b1);
    issue(1'b0, 3'd1, 32'hFFFF, 32'd1, 1'b1, 32'd0, 1'b1);
    idle();
    tick(2);

    // Multiply latency and overflow flag.
    dc0 = dc16;
    issue(1'b0, 3'd3, 32'd5, 32'd2, 1'b1, 32'd10, 1'b0);
    idle();
    count_busy(1'b0, 16, "mul_busy_cycles16");
    tick(3);
    check("mul_done_count", 64'(dc16 - dc0), 64'd1);
    issue(1'b0, 3'd3, 32'h0100, 32'h0100, 1'b1, 32'd0, 1'b1);
    idle();
    count_busy(1'b0, 16, "mul_ovf_busy16");
    tick(2);

    // Requests during a multiply are ignored.
    dc0 = dc16;
    issue(1'b0, 3'd3, 32'd3, 32'd4, 1'b1, 32'd12, 1'b0);
    g = 0;
    while (bus16.busy && g < 100) begin
      bus16.start = 1'b1; bus16.operation = 3'd1;
      bus16.in_AC = 16'($urandom); bus16.in_bus = 16'($urandom);
      @(posedge clk); #1;
      g++;
    end
    idle();
    tick(3);
    check("ignored_start_done_count", 64'(dc16 - dc0), 64'd1);

    // Reset aborts an in-flight multiply.
    issue(1'b0, 3'd3, 32'd7, 32'd9, 1'b1, 32'd63, 1'b0);
    idle();
    tick(7);
    rst = 1'b1;
    q16.delete();
    dc0 = dc16;
    tick(1);
    rst = 1'b0;
    check("abort_data_out", {48'd0, bus16.data_out}, 64'd0);
    check("abort_zero", {63'd0, bus16.zero}, 64'd0);
    check("abort_carry", {63'd0, bus16.carry}, 64'd0);
    check("abort_busy", {63'd0, bus16.busy}, 64'd0);
    check("abort_done", {63'd0, bus16.done}, 64'd0);
    tick(20);
    check("abort_no_done", 64'(dc16 - dc0), 64'd0);
    issue(1'b0, 3'd1, 32'd1, 32'd1, 1'b1, 32'd2, 1'b0);
    idle();
    tick(1);
    check("post_abort_add_done", 64'(dc16 - dc0), 64'd1);

    random_run(1'b0, 150);
    tick(20);

    // Narrow instance.
    issue(1'b1, 3'd3, 32'h10, 32'h10, 1'b1, 32'h00, 1'b1);
    idle();
    count_busy(1'b1, 8, "mul_busy_cycles8");
    issue(1'b1, 3'd4, 32'hFF, 32'd0, 1'b1, 32'h00, 1'b1);
    idle();
    tick(1);
    random_run(1'b1, 80);

    g = 0;
    while ((q16.size() != 0 || q8.size() != 0) && g < 100) begin
      tick(1);
      g++;
    end
    tick(2);
    check("q16_drained", 64'(q16.size()), 64'd0);
    check("q8_drained", 64'(q8.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
